// File: rtl/dit_ntt_scheduler_pkg.sv
// Shared types and latency constants for the DIT NTT scheduler.
// Latency: n/a; no backpressure.
package dit_ntt_scheduler_pkg;

    localparam int INTMUL_DELAY   = 1;
    localparam int MODRED_DELAY   = 1;
    localparam int BF_LATENCY_DEF = INTMUL_DELAY + MODRED_DELAY + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/delay_n_cycles.sv
// Fixed-length register delay line; reset clears every stage.
// Latency: N cycles; no backpressure (accepts a word every cycle).
module delay_n_cycles #(
    parameter int W = 1,
    parameter int N = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] pipe [N];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= d;
            for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign q = pipe[N-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// Maps (stage, pair index, op) to butterfly read addresses and twiddle index.
// Latency: combinational; no backpressure.
module ntt_addr_gen #(
    parameter int LOG_N = 8
) (
    input  logic             op,
    input  logic [LOG_N-1:0] s,
    input  logic [LOG_N-1:0] k,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-2:0] tw_addr
);

    localparam logic [LOG_N-1:0] ONE = LOG_N'(1);

    logic [LOG_N-1:0] half;
    logic [LOG_N-1:0] j;
    logic [LOG_N-1:0] g;
    logic [LOG_N-1:0] base;

    always_comb begin
        half = ONE << s;
        j    = k & (half - ONE);
        g    = k >> s;
        // Group g spans 2*half words; j is the offset inside its lower half.
        base = (g << (s + 1)) | j;

        rd_addr_a = base;
        rd_addr_b = base + half;
        tw_addr   = j[LOG_N-2:0] << (LOG_N - 1 - s);
        if (op) begin
            rd_addr_a = k;
            rd_addr_b = k;
            tw_addr   = '0;
        end
    end

endmodule

// File: rtl/dit_ntt_scheduler.sv
// Drives one butterfly through an in-place radix-2 DIT NTT (or a pointwise scale pass) over RAM.
// Latency: reads issue 1/cycle, writes land 1+BF_LATENCY later; stages drain fully, no backpressure.
module dit_ntt_scheduler
    import dit_ntt_scheduler_pkg::*;
#(
    parameter int LOG_N      = 8,
    parameter int BF_LATENCY = BF_LATENCY_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    output logic             busy,
    output logic             done,
    output logic [LOG_N-1:0] stage,
    output logic             rd_en,
    output logic [LOG_N-1:0] rd_addr_a,
    output logic [LOG_N-1:0] rd_addr_b,
    output logic [LOG_N-2:0] tw_addr,
    output logic             bf_mode,
    output logic             bf_swap,
    output logic             wr_en_a,
    output logic             wr_en_b,
    output logic [LOG_N-1:0] wr_addr_a,
    output logic [LOG_N-1:0] wr_addr_b
);

    localparam int               DW         = $clog2(BF_LATENCY + 1) + 1;
    localparam logic [LOG_N-1:0] ONE        = LOG_N'(1);
    localparam logic [LOG_N-1:0] K_LAST_NTT = {1'b0, {(LOG_N-1){1'b1}}};
    localparam logic [LOG_N-1:0] K_LAST_SCL = '1;
    localparam logic [LOG_N-1:0] S_LAST     = LOG_N'(LOG_N - 1);
    localparam logic [DW-1:0]    DRAIN_LAST = DW'(BF_LATENCY);

    typedef struct packed {
        logic             vld;
        logic             op;
        logic [LOG_N-1:0] addr_a;
        logic [LOG_N-1:0] addr_b;
    } wb_t;

    state_t           state, state_nxt;
    logic [LOG_N-1:0] s, k;
    logic             op_q;
    logic [DW-1:0]    drain_cnt;
    logic [LOG_N-1:0] gen_a, gen_b;
    logic [LOG_N-2:0] gen_tw;
    logic             k_at_last, drain_done, last_pass;
    wb_t              wb_in, wb_out;

    ntt_addr_gen #(.LOG_N(LOG_N)) u_addr_gen (
        .op        (op_q),
        .s         (s),
        .k         (k),
        .rd_addr_a (gen_a),
        .rd_addr_b (gen_b),
        .tw_addr   (gen_tw)
    );

    assign k_at_last  = (k == (op_q ? K_LAST_SCL : K_LAST_NTT));
    assign drain_done = (drain_cnt == DRAIN_LAST);
    assign last_pass  = op_q || (s == S_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = ISSUE;
            end
            ISSUE: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (k_at_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                // Exit the cycle the last write lands so the next pass reads fresh data.
                if (drain_done) state_nxt = last_pass ? DONE : ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s         <= '0;
            k         <= '0;
            op_q      <= 1'b0;
            drain_cnt <= '0;
            bf_mode   <= 1'b0;
            bf_swap   <= 1'b0;
        end else begin
            bf_mode <= rd_en & op_q;
            bf_swap <= rd_en & op_q;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
                        s    <= '0;
                        k    <= '0;
                    end
                end
                ISSUE: begin
                    k         <= k + ONE;
                    drain_cnt <= '0;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + DW'(1);
                    if (drain_done) begin
                        k <= '0;
                        if (!last_pass) s <= s + ONE;
                    end
                end
                DONE:    s <= '0;
                default: ;
            endcase
        end
    end

    assign stage     = s;
    assign rd_addr_a = rd_en ? gen_a  : '0;
    assign rd_addr_b = rd_en ? gen_b  : '0;
    assign tw_addr   = rd_en ? gen_tw : '0;

    assign wb_in = '{vld: rd_en, op: op_q, addr_a: rd_addr_a, addr_b: rd_addr_b};

    delay_n_cycles #(.W($bits(wb_t)), .N(1 + BF_LATENCY)) u_wb_delay (
        .clk   (clk),
        .reset (reset),
        .d     (wb_in),
        .q     (wb_out)
    );

    assign wr_en_a   = wb_out.vld;
    assign wr_en_b   = wb_out.vld & ~wb_out.op;
    assign wr_addr_a = wb_out.addr_a;
    assign wr_addr_b = wb_out.addr_b;

endmodule

// File: tb/tb_dit_ntt_scheduler.sv
// Directed bench: per-cycle comparison of every scheduler output against hand-derived schedules.
module tb_dit_ntt_scheduler;

    localparam int LOG_N  = 3;
    localparam int BF_LAT = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic             op = 1'b0;
    logic             busy, done, rd_en, bf_mode, bf_swap, wr_en_a, wr_en_b;
    logic [LOG_N-1:0] stage, rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [LOG_N-2:0] tw_addr;

    int n_err = 0;
    int n_chk = 0;

    // Hand-derived pair schedule for N=8: [stage][pair]
    int tab_a  [3][4] = '{'{0, 2, 4, 6}, '{0, 1, 4, 5}, '{0, 1, 2, 3}};
    int tab_b  [3][4] = '{'{1, 3, 5, 7}, '{2, 3, 6, 7}, '{4, 5, 6, 7}};
    int tab_tw [3][4] = '{'{0, 0, 0, 0}, '{0, 2, 0, 2}, '{0, 1, 2, 3}};

    always #5 clk = ~clk;

    dit_ntt_scheduler #(.LOG_N(LOG_N), .BF_LATENCY(BF_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .busy      (busy),
        .done      (done),
        .stage     (stage),
        .rd_en     (rd_en),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .tw_addr   (tw_addr),
        .bf_mode   (bf_mode),
        .bf_swap   (bf_swap),
        .wr_en_a   (wr_en_a),
        .wr_en_b   (wr_en_b),
        .wr_addr_a (wr_addr_a),
        .wr_addr_b (wr_addr_b)
    );

    logic [23:0] obs;
    assign obs = {busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr, (rd_en ? stage : 3'd0),
                  bf_mode, bf_swap, wr_en_a, wr_en_b, wr_addr_a, wr_addr_b};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, act, exp_v);
        end
    endtask

    // Read issued at relative cycle r (start accepted at cycle 0)?
    function automatic bit read_at(input bit scale, input int r,
                                   output int a, output int b, output int tw, output int p);
        bit hit = 1'b0;
        a = 0; b = 0; tw = 0; p = 0;
        if (scale) begin
            if (r >= 1 && r <= 8) begin
                a = r - 1; b = r - 1; hit = 1'b1;
            end
        end else begin
            for (int pp = 0; pp < 3; pp++)
                for (int i = 0; i < 4; i++)
                    if (r == 1 + 9 * pp + i) begin
                        a = tab_a[pp][i]; b = tab_b[pp][i]; tw = tab_tw[pp][i]; p = pp; hit = 1'b1;
                    end
        end
        return hit;
    endfunction

    function automatic logic [23:0] exp_obs(input bit scale, input int c, input int total, input int rst_at);
        int a, b, tw, p;
        bit hit;
        logic busy_e = 1'b0, done_e = 1'b0, rd_e = 1'b0, m_e = 1'b0, wa_e = 1'b0, wb_e = 1'b0;
        logic [2:0] ra = '0, rb = '0, st = '0, wa = '0, wb = '0;
        logic [1:0] twe = '0;
        if (rst_at >= 0 && c > rst_at) return '0;
        busy_e = (c >= 1 && c < total);
        done_e = (c == total);
        hit = read_at(scale, c, a, b, tw, p);
        if (hit) begin
            rd_e = 1'b1; ra = 3'(a); rb = 3'(b); twe = 2'(tw); st = 3'(p);
        end
        hit = read_at(scale, c - 1, a, b, tw, p);
        if (hit) m_e = scale;
        hit = read_at(scale, c - 1 - BF_LAT, a, b, tw, p);
        if (hit) begin
            wa_e = 1'b1; wb_e = !scale; wa = 3'(a); wb = 3'(b);
        end
        return {busy_e, done_e, rd_e, ra, rb, twe, st, m_e, m_e, wa_e, wb_e, wa, wb};
    endfunction

    // One operation, checked every cycle. poke_at: extra start with flipped op while busy;
    // done_poke: start coincident with done; rst_at: reset pulse at that cycle (-1 = none).
    task automatic run(input string name, input bit scale, input int poke_at,
                       input bit done_poke, input int rst_at);
        int total = scale ? 14 : 28;
        for (int c = 0; c <= total + 3; c++) begin
            chk($sformatf("%s_c%0d", name, c), 32'(obs), 32'(exp_obs(scale, c, total, rst_at)));
            if (rst_at >= 0 && c == rst_at + 1)
                chk($sformatf("%s_stage_rst", name), 32'(stage), 32'd0);
            start = (c == 0) || (c == poke_at) || (done_poke && c == total);
            if (c == 0) op = scale;
            else if (c == poke_at) op = ~scale;
            reset = (c == rst_at);
            @(negedge clk);
        end
        op = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_obs", 32'(obs), 32'd0);
        chk("reset_stage", 32'(stage), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run("ntt",        1'b0, -1, 1'b0, -1);
        run("scale",      1'b1, -1, 1'b0, -1);
        run("busy_poke",  1'b0,  3, 1'b0, -1);
        run("done_poke",  1'b0, -1, 1'b1, -1);
        run("mid_rst",    1'b0, -1, 1'b0, 15);
        run("after_rst",  1'b0, -1, 1'b0, -1);
        run("scale_poke", 1'b1,  5, 1'b1, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
